// File: rtl/lcd_par8_driver.sv
`timescale 1ns/1ps
// lcd_par8_driver
// Byte-serialising driver for an ILI9341 panel on an 8-bit 8080-style bus.
// After reset it runs the panel power-up/init sequence by itself. It then
// streams one RGB565 pixel per accepted pix_clk as two data writes. A
// reset_cursor pulse re-sends the column/row window so GRAM writes restart
// at (0,0).
//
// Ports
//   clk_16MHz    in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   pix_data     in   RGB565 pixel, sampled only on an accepted pix_clk
//   pix_clk      in   one-cycle pixel strobe
//   reset_cursor in   one-cycle request to re-home the write window
//   busy         out  pix_clk is not accepted while high
//   nreset       out  panel RESX
//   cmd_data     out  panel D/CX (0 = command, 1 = data)
//   write_edge   out  panel WRX, panel latches on its rising edge
//   dout         out  panel D[7:0]
//
// State table
//   state      | meaning
//   S_RST_LOW  | nreset held low for RESET_HOLD cycles
//   S_RST_WAIT | nreset high, wait RESET_WAIT cycles
//   S_SLPOUT   | write command 0x11
//   S_SLP_WAIT | wait SLEEP_WAIT cycles
//   S_INIT     | stream the 5-byte init list
//   S_WINDOW   | stream the 11-byte window list (cols 0-319, rows 0-239, RAMWR)
//   S_PIXEL    | stream pixel hi byte then lo byte
//   S_IDLE     | accept pix_clk / reset_cursor, serve a pending cursor request
//
// Timing convention: each wait state loads its counter with N-1 and leaves on
// the edge where the counter is already zero, so it occupies exactly N cycles.
// Every byte takes two cycles (write_edge low, then high); the high cycle of
// the last byte of a burst is already S_IDLE with busy low. Counting the
// release of resetn as edge 0, busy first reads low after edge
// RESET_HOLD + RESET_WAIT + SLEEP_WAIT + 33, one cycle ahead of the nominal
// RESET_HOLD + RESET_WAIT + 2 + SLEEP_WAIT + 32 budget because the final
// rising write_edge and the first idle cycle coincide.

module lcd_par8_driver #(
  parameter int RESET_HOLD = 160,
  parameter int RESET_WAIT = 1920000,
  parameter int SLEEP_WAIT = 1920000
) (
  input  logic        clk_16MHz,
  input  logic        resetn,
  input  logic [15:0] pix_data,
  input  logic        pix_clk,
  input  logic        reset_cursor,
  output logic        busy,
  output logic        nreset,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout
);

  localparam int MAX_HW   = (RESET_HOLD > RESET_WAIT) ? RESET_HOLD : RESET_WAIT;
  localparam int MAX_WAIT = (MAX_HW > SLEEP_WAIT) ? MAX_HW : SLEEP_WAIT;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CW-1:0] HOLD_LD  = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(RESET_WAIT - 1);
  localparam logic [CW-1:0] SLEEP_LD = CW'(SLEEP_WAIT - 1);

  localparam logic [3:0] INIT_LAST = 4'd4;
  localparam logic [3:0] WIN_LAST  = 4'd10;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_SLPOUT,
    S_SLP_WAIT,
    S_INIT,
    S_WINDOW,
    S_PIXEL,
    S_IDLE
  } state_t;

  state_t        state, state_n;
  logic          ph, ph_n;          // 0: write_edge low cycle, 1: high cycle
  logic [3:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, pend_n;
  logic [7:0]    pix_lo, pix_lo_n;

  logic          busy_n, nreset_n, cmd_data_n, write_edge_n;
  logic [7:0]    dout_n;
  logic [8:0]    byte_n;            // {cmd_data, dout} of the byte being started

  function automatic logic [8:0] init_rom(input logic [3:0] i);
    case (i)
      4'd0:    init_rom = {1'b0, 8'h3A};
      4'd1:    init_rom = {1'b1, 8'h55};
      4'd2:    init_rom = {1'b0, 8'h36};
      4'd3:    init_rom = {1'b1, 8'h28};
      default: init_rom = {1'b0, 8'h29};
    endcase
  endfunction

  function automatic logic [8:0] window_rom(input logic [3:0] i);
    case (i)
      4'd0:    window_rom = {1'b0, 8'h2A};
      4'd1:    window_rom = {1'b1, 8'h00};
      4'd2:    window_rom = {1'b1, 8'h00};
      4'd3:    window_rom = {1'b1, 8'h01};
      4'd4:    window_rom = {1'b1, 8'h3F};
      4'd5:    window_rom = {1'b0, 8'h2B};
      4'd6:    window_rom = {1'b1, 8'h00};
      4'd7:    window_rom = {1'b1, 8'h00};
      4'd8:    window_rom = {1'b1, 8'h00};
      4'd9:    window_rom = {1'b1, 8'hEF};
      default: window_rom = {1'b0, 8'h2C};
    endcase
  endfunction

  always_ff @(posedge clk_16MHz or negedge resetn) begin
    if (!resetn) begin
      state      <= S_RST_LOW;
      ph         <= 1'b0;
      idx        <= '0;
      cnt        <= HOLD_LD;
      pend       <= 1'b0;
      pix_lo     <= '0;
      busy       <= 1'b1;
      nreset     <= 1'b0;
      cmd_data   <= 1'b0;
      write_edge <= 1'b1;
      dout       <= '0;
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      pix_lo     <= pix_lo_n;
      busy       <= busy_n;
      nreset     <= nreset_n;
      cmd_data   <= cmd_data_n;
      write_edge <= write_edge_n;
      dout       <= dout_n;
    end
  end

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    idx_n    = idx;
    cnt_n    = cnt;
    // A cursor request seen while busy is remembered once; repeats merge.
    pend_n   = pend | (busy & reset_cursor);
    pix_lo_n = pix_lo;

    case (state)
      S_RST_LOW: begin
        if (cnt == '0) begin
          state_n = S_RST_WAIT;
          cnt_n   = WAIT_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt == '0) begin
          state_n = S_SLPOUT;
          ph_n    = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_SLPOUT: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          state_n = S_SLP_WAIT;
          cnt_n   = SLEEP_LD;
        end
      end
      S_SLP_WAIT: begin
        if (cnt == '0) begin
          state_n = S_INIT;
          idx_n   = '0;
          ph_n    = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_INIT: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else if (idx == INIT_LAST) begin
          state_n = S_WINDOW;
          idx_n   = '0;
          ph_n    = 1'b0;
        end else begin
          idx_n = idx + 4'd1;
          ph_n  = 1'b0;
        end
      end
      S_WINDOW: begin
        if (!ph) begin
          // The rising cycle of the last byte is spent in idle.
          if (idx == WIN_LAST) state_n = S_IDLE;
          ph_n = 1'b1;
        end else begin
          idx_n = idx + 4'd1;
          ph_n  = 1'b0;
        end
      end
      S_PIXEL: begin
        if (!ph) begin
          if (idx != '0) state_n = S_IDLE;
          ph_n = 1'b1;
        end else begin
          idx_n = 4'd1;
          ph_n  = 1'b0;
        end
      end
      S_IDLE: begin
        if (pend) begin
          state_n = S_WINDOW;
          idx_n   = '0;
          ph_n    = 1'b0;
          pend_n  = busy & reset_cursor;
        end else if (reset_cursor) begin
          state_n = S_WINDOW;
          idx_n   = '0;
          ph_n    = 1'b0;
        end else if (pix_clk) begin
          state_n  = S_PIXEL;
          idx_n    = '0;
          ph_n     = 1'b0;
          pix_lo_n = pix_data[7:0];
        end
      end
      default: state_n = S_RST_LOW;
    endcase
  end

  always_comb begin
    case (state_n)
      S_SLPOUT: byte_n = {1'b0, 8'h11};
      S_INIT:   byte_n = init_rom(idx_n);
      S_WINDOW: byte_n = window_rom(idx_n);
      S_PIXEL:  byte_n = (idx_n == '0) ? {1'b1, pix_data[15:8]} : {1'b1, pix_lo};
      default:  byte_n = {cmd_data, dout};
    endcase

    nreset_n = (state_n != S_RST_LOW);
    // Idle with a cursor request still pending is not free for pixels.
    busy_n   = !((state_n == S_IDLE) && !pend_n);

    write_edge_n = 1'b1;
    cmd_data_n   = cmd_data;
    dout_n       = dout;
    // Bus data only moves together with a falling write_edge.
    if (!ph_n && (state_n inside {S_SLPOUT, S_INIT, S_WINDOW, S_PIXEL})) begin
      write_edge_n = 1'b0;
      cmd_data_n   = byte_n[8];
      dout_n       = byte_n[7:0];
    end
  end

endmodule
